// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for one issue lane: decodes the ALU function, forwards
// MEM/WB results onto the EX operands and raises load-use hazard stalls.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_fwd_en,
  input  logic [RW-1:0] mem_fwd_rd,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          wb_fwd_en,
  input  logic [RW-1:0] wb_fwd_rd,
  input  logic [DW-1:0] wb_fwd_data,
  output logic          ex_valid,
  output logic [DW-1:0] ex_in1,
  output logic [DW-1:0] ex_in2,
  output logic [3:0]    ex_func,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_branch_eq,
  output logic          ex_branch_ne,
  output logic          ex_illegal,
  output logic          hazard_stall
);

  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_OR  = 4'b0001;
  localparam logic [3:0] FN_ADD = 4'b0010;
  localparam logic [3:0] FN_SUB = 4'b1010;
  localparam logic [3:0] FN_SLT = 4'b1011;
  localparam logic [3:0] FN_XOR = 4'b0100;
  localparam logic [3:0] FN_LUI = 4'b0101;

  logic [3:0]    dec_func;
  logic [RW-1:0] dec_dest;
  logic          dec_use_imm, dec_reg_write, dec_mem_read, dec_mem_write;
  logic          dec_branch_eq, dec_branch_ne, dec_illegal, dec_reads_rt;

  logic          valid_reg;
  logic [3:0]    func_reg;
  logic [RW-1:0] rs_reg, rt_reg, dest_reg;
  logic [DW-1:0] rs_data_reg, rt_data_reg, imm_reg;
  logic          use_imm_reg, reg_write_reg, mem_read_reg, mem_write_reg;
  logic          branch_eq_reg, branch_ne_reg, illegal_reg;

  always_comb begin
    dec_func      = FN_AND;
    dec_dest      = '0;
    dec_use_imm   = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch_eq = 1'b0;
    dec_branch_ne = 1'b0;
    dec_illegal   = 1'b0;
    dec_reads_rt  = 1'b0;
    case (id_opcode)
      6'h00: begin
        dec_reads_rt  = 1'b1;
        dec_dest      = id_rd;
        dec_reg_write = 1'b1;
        case (id_funct)
          6'h20, 6'h21: dec_func = FN_ADD;
          6'h22, 6'h23: dec_func = FN_SUB;
          6'h24:        dec_func = FN_AND;
          6'h25:        dec_func = FN_OR;
          6'h26:        dec_func = FN_XOR;
          6'h2A:        dec_func = FN_SLT;
          default: begin
            dec_illegal   = 1'b1;
            dec_dest      = '0;
            dec_reg_write = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec_dest      = id_rt;
        dec_use_imm   = 1'b1;
        dec_reg_write = 1'b1;
        case (id_opcode)
          6'h0A:   dec_func = FN_SLT;
          6'h0C:   dec_func = FN_AND;
          6'h0D:   dec_func = FN_OR;
          6'h0E:   dec_func = FN_XOR;
          6'h0F:   dec_func = FN_LUI;
          default: dec_func = FN_ADD;
        endcase
      end
      6'h23: begin
        dec_func      = FN_ADD;
        dec_dest      = id_rt;
        dec_use_imm   = 1'b1;
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
      end
      6'h2B: begin
        dec_func      = FN_ADD;
        dec_use_imm   = 1'b1;
        dec_mem_write = 1'b1;
        dec_reads_rt  = 1'b1;
      end
      6'h04, 6'h05: begin
        dec_func      = FN_SUB;
        dec_reads_rt  = 1'b1;
        dec_branch_eq = (id_opcode == 6'h04);
        dec_branch_ne = (id_opcode == 6'h05);
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // A load in EX whose result the ID instruction needs cannot be forwarded in time.
  assign hazard_stall = !flush && valid_reg && mem_read_reg && (dest_reg != '0) && id_valid &&
                        ((id_rs == dest_reg) || (dec_reads_rt && (id_rt == dest_reg)));

  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && hazard_stall)) begin
      valid_reg     <= 1'b0;
      func_reg      <= '0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      dest_reg      <= '0;
      rs_data_reg   <= '0;
      rt_data_reg   <= '0;
      imm_reg       <= '0;
      use_imm_reg   <= 1'b0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      branch_eq_reg <= 1'b0;
      branch_ne_reg <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (!stall) begin
      valid_reg     <= id_valid;
      func_reg      <= dec_func;
      rs_reg        <= id_rs;
      rt_reg        <= id_rt;
      dest_reg      <= dec_dest;
      rs_data_reg   <= id_rs_data;
      rt_data_reg   <= id_rt_data;
      imm_reg       <= id_imm;
      use_imm_reg   <= dec_use_imm;
      reg_write_reg <= id_valid && dec_reg_write && (dec_dest != '0);
      mem_read_reg  <= id_valid && dec_mem_read;
      mem_write_reg <= id_valid && dec_mem_write;
      branch_eq_reg <= id_valid && dec_branch_eq;
      branch_ne_reg <= id_valid && dec_branch_ne;
      illegal_reg   <= id_valid && dec_illegal;
    end
  end

  // Operand 0 is rs, operand 1 is rt; MEM beats WB, register 0 is never forwarded.
  logic [RW-1:0] src_idx  [2];
  logic [DW-1:0] src_data [2];
  logic [DW-1:0] fwd_val  [2];

  assign src_idx[0]  = rs_reg;
  assign src_idx[1]  = rt_reg;
  assign src_data[0] = rs_data_reg;
  assign src_data[1] = rt_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_val[gi] =
        (mem_fwd_en && (mem_fwd_rd == src_idx[gi]) && (src_idx[gi] != '0)) ? mem_fwd_data :
        (wb_fwd_en  && (wb_fwd_rd  == src_idx[gi]) && (src_idx[gi] != '0)) ? wb_fwd_data  :
        src_data[gi];
    end
  endgenerate

  assign ex_valid      = valid_reg;
  assign ex_func       = func_reg;
  assign ex_in1        = fwd_val[0];
  assign ex_in2        = use_imm_reg ? imm_reg : fwd_val[1];
  assign ex_store_data = fwd_val[1];
  assign ex_dest       = dest_reg;
  assign ex_reg_write  = reg_write_reg;
  assign ex_mem_read   = mem_read_reg;
  assign ex_mem_write  = mem_write_reg;
  assign ex_branch_eq  = branch_eq_reg;
  assign ex_branch_ne  = branch_ne_reg;
  assign ex_illegal    = illegal_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX snapshots are queued as stimulus
// is driven and popped when the EX slot settles.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, id_valid, stall, flush;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch_eq, ex_branch_ne, ex_illegal, hazard_stall;
  logic [31:0] ex_in1, ex_in2, ex_store_data;
  logic [3:0]  ex_func;
  logic [4:0]  ex_dest;

  int checks = 0;
  int errors = 0;
  logic [111:0] exp_q [$];

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .stall(stall), .flush(flush),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_func(ex_func),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch_eq(ex_branch_eq),
    .ex_branch_ne(ex_branch_ne), .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
  );

  // {valid, func, in1, in2, store, dest, rw, mr, mw, beq, bne, ill}
  wire [111:0] obs_vec = {ex_valid, ex_func, ex_in1, ex_in2, ex_store_data, ex_dest,
                          ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_eq, ex_branch_ne, ex_illegal};

  function automatic logic [111:0] exp_vec(input logic v, input logic [3:0] fn,
      input logic [31:0] in1, input logic [31:0] in2, input logic [31:0] sd, input logic [4:0] dest,
      input logic rw, input logic mr, input logic mw, input logic be, input logic bn, input logic ill);
    return {v, fn, in1, in2, sd, dest, rw, mr, mw, be, bn, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
      input logic [31:0] imm, input logic v);
    id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_valid = v;
  endtask

  task automatic clear_fwd();
    mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
  endtask

  task automatic test_reset();
    logic [111:0] e;
    reset = 1; stall = 0; flush = 0; clear_fwd();
    drive_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, 1'b1);
    exp_q.push_back('0);
    tick(); tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL reset_init got=%h want=%h", obs_vec, e); end
    else $display("reset_init ok ex=%h", obs_vec);
    reset = 0;
    exp_q.push_back(exp_vec(1, 4'b0010, 32'd5, 32'd6, 32'd6, 5'd3, 1, 0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL reset_add got=%h want=%h", obs_vec, e); end
    else $display("reset_add ok ex=%h", obs_vec);
    reset = 1; stall = 1;
    exp_q.push_back('0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL reset_midstream got=%h want=%h", obs_vec, e); end
    else $display("reset_midstream ok ex=%h", obs_vec);
    reset = 0; stall = 0;
  endtask

  task automatic test_rtype_sub();
    logic [111:0] e;
    drive_id(6'h00, 6'h22, 5'd3, 5'd4, 5'd5, 32'd10, 32'd3, 32'h0, 1'b1);
    exp_q.push_back(exp_vec(1, 4'b1010, 32'd10, 32'd3, 32'd3, 5'd5, 1, 0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL rtype_sub got=%h want=%h", obs_vec, e); end
    else $display("rtype_sub ok ex=%h", obs_vec);
    drive_id(6'h00, 6'h2A, 5'd6, 5'd7, 5'd8, 32'd1, 32'd2, 32'h0, 1'b1);
    exp_q.push_back(exp_vec(1, 4'b1011, 32'd1, 32'd2, 32'd2, 5'd8, 1, 0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL rtype_slt got=%h want=%h", obs_vec, e); end
    else $display("rtype_slt ok ex=%h", obs_vec);
  endtask

  task automatic test_forward();
    logic [111:0] e;
    drive_id(6'h00, 6'h20, 5'd7, 5'd9, 5'd10, 32'h1111, 32'h2222, 32'h0, 1'b1);
    tick();
    stall = 1;
    mem_fwd_en = 1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'hAAAA;
    wb_fwd_en = 1;  wb_fwd_rd = 5'd7;  wb_fwd_data = 32'hBBBB;
    exp_q.push_back(exp_vec(1, 4'b0010, 32'hAAAA, 32'h2222, 32'h2222, 5'd10, 1, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL fwd_mem_beats_wb got=%h want=%h", obs_vec, e); end
    else $display("fwd_mem_beats_wb ok ex=%h", obs_vec);
    mem_fwd_en = 0; wb_fwd_rd = 5'd9;
    exp_q.push_back(exp_vec(1, 4'b0010, 32'h1111, 32'hBBBB, 32'hBBBB, 5'd10, 1, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL fwd_wb_rt got=%h want=%h", obs_vec, e); end
    else $display("fwd_wb_rt ok ex=%h", obs_vec);
    stall = 0; clear_fwd();
    drive_id(6'h00, 6'h20, 5'd0, 5'd0, 5'd1, 32'h55, 32'h66, 32'h0, 1'b1);
    tick();
    mem_fwd_en = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hAAAA;
    wb_fwd_en = 1;  wb_fwd_rd = 5'd0;  wb_fwd_data = 32'hBBBB;
    exp_q.push_back(exp_vec(1, 4'b0010, 32'h55, 32'h66, 32'h66, 5'd1, 1, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL fwd_r0_blocked got=%h want=%h", obs_vec, e); end
    else $display("fwd_r0_blocked ok ex=%h", obs_vec);
    clear_fwd();
  endtask

  task automatic test_load_use();
    logic [111:0] e;
    drive_id(6'h23, 6'h00, 5'd2, 5'd8, 5'd0, 32'h100, 32'h77, 32'd4, 1'b1);
    exp_q.push_back(exp_vec(1, 4'b0010, 32'h100, 32'd4, 32'h77, 5'd8, 1, 1, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL lw_issue got=%h want=%h", obs_vec, e); end
    else $display("lw_issue ok ex=%h", obs_vec);
    drive_id(6'h00, 6'h20, 5'd8, 5'd1, 5'd9, 32'h0, 32'd3, 32'h0, 1'b1);
    #1; checks++;
    if (hazard_stall !== 1'b1) begin errors++; $display("FAIL hazard_assert got=%b want=1", hazard_stall); end
    else $display("hazard_assert ok");
    flush = 1;
    #1; checks++;
    if (hazard_stall !== 1'b0) begin errors++; $display("FAIL hazard_flush_mask got=%b want=0", hazard_stall); end
    else $display("hazard_flush_mask ok");
    flush = 0;
    exp_q.push_back('0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL load_use_bubble got=%h want=%h", obs_vec, e); end
    else $display("load_use_bubble ok ex=%h", obs_vec);
    checks++;
    if (hazard_stall !== 1'b0) begin errors++; $display("FAIL hazard_deassert got=%b want=0", hazard_stall); end
    else $display("hazard_deassert ok");
    wb_fwd_en = 1; wb_fwd_rd = 5'd8; wb_fwd_data = 32'h40;
    exp_q.push_back(exp_vec(1, 4'b0010, 32'h40, 32'd3, 32'd3, 5'd9, 1, 0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL load_use_wb_fwd got=%h want=%h", obs_vec, e); end
    else $display("load_use_wb_fwd ok ex=%h", obs_vec);
    clear_fwd();
  endtask

  task automatic test_stall_flush();
    logic [111:0] e;
    drive_id(6'h0D, 6'h00, 5'd2, 5'd6, 5'd0, 32'h0F00, 32'h9, 32'h00FF, 1'b1);
    tick();
    stall = 1;
    drive_id(6'h00, 6'h20, 5'd11, 5'd12, 5'd13, 32'h1, 32'h2, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_vec(1, 4'b0001, 32'h0F00, 32'h00FF, 32'h9, 5'd6, 1, 0, 0, 0, 0, 0));
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs_vec !== e) begin errors++; $display("FAIL stall_hold_%0d got=%h want=%h", i, obs_vec, e); end
      else $display("stall_hold_%0d ok ex=%h", i, obs_vec);
    end
    flush = 1;
    exp_q.push_back('0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL flush_over_stall got=%h want=%h", obs_vec, e); end
    else $display("flush_over_stall ok ex=%h", obs_vec);
    flush = 0; stall = 0;
  endtask

  task automatic test_lui_illegal();
    logic [111:0] e;
    drive_id(6'h0F, 6'h00, 5'd0, 5'd11, 5'd0, 32'h0, 32'h5, 32'h00001234, 1'b1);
    exp_q.push_back(exp_vec(1, 4'b0101, 32'h0, 32'h00001234, 32'h5, 5'd11, 1, 0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL lui got=%h want=%h", obs_vec, e); end
    else $display("lui ok ex=%h", obs_vec);
    drive_id(6'h3F, 6'h00, 5'd1, 5'd12, 5'd13, 32'h7, 32'h8, 32'h0, 1'b1);
    exp_q.push_back(exp_vec(1, 4'b0000, 32'h7, 32'h8, 32'h8, 5'd0, 0, 0, 0, 0, 0, 1));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL illegal_op got=%h want=%h", obs_vec, e); end
    else $display("illegal_op ok ex=%h", obs_vec);
  endtask

  task automatic test_back_to_back();
    logic [111:0] e;
    drive_id(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 32'h10, 1'b1);
    exp_q.push_back(exp_vec(1, 4'b1010, 32'd5, 32'd5, 32'd5, 5'd0, 0, 0, 0, 1, 0, 0));
    tick();
    drive_id(6'h2B, 6'h00, 5'd3, 5'd4, 5'd0, 32'h200, 32'hDEAD, 32'd8, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL b2b_beq got=%h want=%h", obs_vec, e); end
    else $display("b2b_beq ok ex=%h", obs_vec);
    exp_q.push_back(exp_vec(1, 4'b0010, 32'h200, 32'd8, 32'hDEAD, 5'd0, 0, 0, 1, 0, 0, 0));
    tick();
    drive_id(6'h05, 6'h00, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 32'h0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL b2b_sw got=%h want=%h", obs_vec, e); end
    else $display("b2b_sw ok ex=%h", obs_vec);
    exp_q.push_back(exp_vec(0, 4'b1010, 32'd1, 32'd2, 32'd2, 5'd0, 0, 0, 0, 0, 0, 0));
    tick();
    drive_id(6'h08, 6'h00, 5'd2, 5'd0, 5'd0, 32'h30, 32'h0, 32'hFFFFFFFF, 1'b1);
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL b2b_invalid got=%h want=%h", obs_vec, e); end
    else $display("b2b_invalid ok ex=%h", obs_vec);
    exp_q.push_back(exp_vec(1, 4'b0010, 32'h30, 32'hFFFFFFFF, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs_vec !== e) begin errors++; $display("FAIL b2b_addi_r0 got=%h want=%h", obs_vec, e); end
    else $display("b2b_addi_r0 ok ex=%h", obs_vec);
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    drive_id(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    clear_fwd();
    test_reset();
    test_rtype_sub();
    test_forward();
    test_load_use();
    test_stall_flush();
    test_lui_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
